// File: rtl/baw_round_sequencer.sv
// Turn/round sequencer for the black-and-white tile game: P1 and P2 submit, then compare, then score.
// Latency: a button edge takes effect one cycle after it is registered; the comparator result is sampled one cycle after cmp_start.
// No backpressure: edges not usable in the current state are dropped. TURN_TIMEOUT_EN adds an auto-submit turn timer.
module baw_round_sequencer #(
    parameter int NUM_TILES      = 9,
    parameter int WIN_TARGET     = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 btn_start,
    input  logic                 btn_p1,
    input  logic                 btn_p2,
    input  logic                 btn_confirm,
    input  logic                 btn_restart,
    input  logic [NUM_TILES-1:0] tile_sw,
    input  logic [1:0]           matchresult,
    output logic [2:0]           state,
    output logic [3:0]           p1_handcard,
    output logic [3:0]           p2_handcard,
    output logic                 cmp_start,
    output logic                 scoreupdate_pulse,
    output logic [3:0]           round,
    output logic [3:0]           win,
    output logic [3:0]           lose,
    output logic                 fin,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_P1    = 3'd2,
        S_P2    = 3'd3,
        S_CMP   = 3'd4,
        S_RES   = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    state_t st, st_nxt;

    // bit order: {restart, confirm, p1, p2, start}
    logic [4:0] btn_r, btn_d, edg;
    logic ev_restart, ev_confirm, ev_p1, ev_p2, ev_start;

    logic                 cmp_phase, cmp_phase_nxt;
    logic [NUM_TILES-1:0] p1_used, p2_used, p1_used_nxt, p2_used_nxt;
    logic                 p1_sub, p2_sub, p1_sub_nxt, p2_sub_nxt;
    logic [3:0]           p1_hand_nxt, p2_hand_nxt;
    logic [3:0]           round_nxt, win_nxt, lose_nxt;

    logic [NUM_TILES-1:0] cur_used, sub_mask;
    logic [3:0]           sel_idx, sub_idx;
    logic                 sel_onehot, accept, do_sub;

    assign edg        = btn_r & ~btn_d;
    assign ev_restart = edg[4];
    assign ev_confirm = edg[3] & ~edg[4];
    assign ev_p1      = edg[2] & ~|edg[4:3];
    assign ev_p2      = edg[1] & ~|edg[4:2];
    assign ev_start   = edg[0] & ~|edg[4:1];

    assign state = st;
    assign fin   = (win == 4'(WIN_TARGET)) | (lose == 4'(WIN_TARGET)) | (round == 4'(NUM_TILES));

    assign cur_used   = (st == S_P2) ? p2_used : p1_used;
    assign sel_onehot = (tile_sw != '0) && ((tile_sw & (tile_sw - NUM_TILES'(1))) == '0);
    assign accept     = sel_onehot && ((tile_sw & cur_used) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (tile_sw[i]) sel_idx = 4'(i);
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit, low_vld;
    logic [3:0]     low_idx;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        low_idx = '0;
        low_vld = 1'b0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (!cur_used[i]) begin
                low_idx = 4'(i);
                low_vld = 1'b1;
            end
        end
    end

    // Reloads on entry to a turn, saturates at expiry until a submission leaves the turn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                        tmo_cnt <= '0;
        else if ((st == S_P1 || st == S_P2) && st_nxt == st) tmo_cnt <= tmo_hit ? tmo_cnt : tmo_cnt + TW'(1);
        else                                                tmo_cnt <= '0;
    end
`endif

    always_comb begin
        st_nxt            = st;
        cmp_phase_nxt     = 1'b0;
        p1_used_nxt       = p1_used;
        p2_used_nxt       = p2_used;
        p1_sub_nxt        = p1_sub;
        p2_sub_nxt        = p2_sub;
        p1_hand_nxt       = p1_handcard;
        p2_hand_nxt       = p2_handcard;
        round_nxt         = round;
        win_nxt           = win;
        lose_nxt          = lose;
        cmp_start         = 1'b0;
        scoreupdate_pulse = 1'b0;
        err               = 1'b0;
        do_sub            = 1'b0;
        sub_idx           = sel_idx;
        sub_mask          = tile_sw;
        if (ev_restart) begin
            st_nxt      = S_IDLE;
            p1_used_nxt = '0;
            p2_used_nxt = '0;
            p1_sub_nxt  = 1'b0;
            p2_sub_nxt  = 1'b0;
            p1_hand_nxt = '0;
            p2_hand_nxt = '0;
            round_nxt   = '0;
            win_nxt     = '0;
            lose_nxt    = '0;
        end else begin
            case (st)
                S_IDLE: if (ev_start) st_nxt = S_READY;
                S_READY: begin
                    if (ev_p1 && !p1_sub)      st_nxt = S_P1;
                    else if (ev_p2 && !p2_sub) st_nxt = S_P2;
                end
                S_P1, S_P2: begin
                    if (ev_confirm) begin
                        if (accept) do_sub = 1'b1;
                        else        err    = 1'b1;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (tmo_hit && low_vld) begin
                        do_sub   = 1'b1;
                        sub_idx  = low_idx;
                        sub_mask = NUM_TILES'(1) << low_idx;
                    end
`endif
                    if (do_sub) begin
                        if (st == S_P1) begin
                            p1_hand_nxt = sub_idx;
                            p1_used_nxt = p1_used | sub_mask;
                            p1_sub_nxt  = 1'b1;
                            st_nxt      = p2_sub ? S_CMP : S_READY;
                        end else begin
                            p2_hand_nxt = sub_idx;
                            p2_used_nxt = p2_used | sub_mask;
                            p2_sub_nxt  = 1'b1;
                            st_nxt      = p1_sub ? S_CMP : S_READY;
                        end
                    end
                end
                S_CMP: begin
                    if (!cmp_phase) begin
                        cmp_start     = 1'b1;
                        cmp_phase_nxt = 1'b1;
                    end else begin
                        st_nxt = S_RES;
                        if (matchresult == 2'b11) begin
                            err = 1'b1;
                        end else if (!fin) begin
                            round_nxt         = round + 4'd1;
                            scoreupdate_pulse = 1'b1;
                            if (matchresult == 2'b01) win_nxt  = win + 4'd1;
                            if (matchresult == 2'b10) lose_nxt = lose + 4'd1;
                        end
                    end
                end
                S_RES: begin
                    if (ev_confirm) begin
                        st_nxt     = fin ? S_OVER : S_READY;
                        p1_sub_nxt = 1'b0;
                        p2_sub_nxt = 1'b0;
                    end
                end
                S_OVER:  st_nxt = S_OVER;
                default: st_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) st <= S_IDLE;
        else         st <= st_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_r       <= '0;
            btn_d       <= '0;
            cmp_phase   <= 1'b0;
            p1_used     <= '0;
            p2_used     <= '0;
            p1_sub      <= 1'b0;
            p2_sub      <= 1'b0;
            p1_handcard <= '0;
            p2_handcard <= '0;
            round       <= '0;
            win         <= '0;
            lose        <= '0;
        end else begin
            btn_r       <= {btn_restart, btn_confirm, btn_p1, btn_p2, btn_start};
            btn_d       <= btn_r;
            cmp_phase   <= cmp_phase_nxt;
            p1_used     <= p1_used_nxt;
            p2_used     <= p2_used_nxt;
            p1_sub      <= p1_sub_nxt;
            p2_sub      <= p2_sub_nxt;
            p1_handcard <= p1_hand_nxt;
            p2_handcard <= p2_hand_nxt;
            round       <= round_nxt;
            win         <= win_nxt;
            lose        <= lose_nxt;
        end
    end

endmodule

// File: tb/tb_baw_round_sequencer.sv
// Bench for baw_round_sequencer: transaction-level game model, per-cycle compare, directed plus random presses.
module tb_baw_round_sequencer;
    localparam int NT = 9;
    localparam int WT = 5;
    localparam bit [4:0] M_RST = 5'b10000, M_CONF = 5'b01000, M_P1 = 5'b00100,
                         M_P2 = 5'b00010, M_START = 5'b00001;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic btn_start = 1'b0, btn_p1 = 1'b0, btn_p2 = 1'b0, btn_confirm = 1'b0, btn_restart = 1'b0;
    logic [NT-1:0] tile_sw = '0;
    logic [1:0] matchresult = 2'b00;
    logic [2:0] state;
    logic [3:0] p1_handcard, p2_handcard, round, win, lose;
    logic cmp_start, scoreupdate_pulse, fin, err;

    baw_round_sequencer #(.NUM_TILES(NT), .WIN_TARGET(WT), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .resetn(resetn),
        .btn_start(btn_start), .btn_p1(btn_p1), .btn_p2(btn_p2),
        .btn_confirm(btn_confirm), .btn_restart(btn_restart),
        .tile_sw(tile_sw), .matchresult(matchresult),
        .state(state), .p1_handcard(p1_handcard), .p2_handcard(p2_handcard),
        .cmp_start(cmp_start), .scoreupdate_pulse(scoreupdate_pulse),
        .round(round), .win(win), .lose(lose), .fin(fin), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int n_err = 0, n_cmp = 0, n_score = 0;
    bit chk_en = 1'b0;

    // Game model
    int m_st, m_h1, m_h2, m_round, m_win, m_lose;
    bit [NT-1:0] m_used1, m_used2;
    bit m_sub1, m_sub2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fin();
        return (m_win == WT) || (m_lose == WT) || (m_round == NT);
    endfunction

    task automatic model_clear();
        m_st = 0; m_h1 = 0; m_h2 = 0; m_round = 0; m_win = 0; m_lose = 0;
        m_used1 = '0; m_used2 = '0; m_sub1 = 1'b0; m_sub2 = 1'b0;
    endtask

    task automatic model_apply(input bit [4:0] m, output bit ee, output bit ec, output bit es);
        int b;
        bit [NT-1:0] used;
        ee = 1'b0; ec = 1'b0; es = 1'b0;
        b = m[3] ? 1 : m[2] ? 2 : m[1] ? 3 : m[0] ? 4 : 0;
        if (m[4]) begin
            model_clear();
        end else begin
            case (m_st)
                0: if (b == 4) m_st = 1;
                1: begin
                    if (b == 2 && !m_sub1)      m_st = 2;
                    else if (b == 3 && !m_sub2) m_st = 3;
                end
                2, 3: if (b == 1) begin
                    used = (m_st == 2) ? m_used1 : m_used2;
                    if ($countones(tile_sw) == 1 && (tile_sw & used) == '0) begin
                        if (m_st == 2) begin m_h1 = $clog2(tile_sw); m_used1 |= tile_sw; m_sub1 = 1'b1; end
                        else           begin m_h2 = $clog2(tile_sw); m_used2 |= tile_sw; m_sub2 = 1'b1; end
                        if (m_sub1 && m_sub2) begin
                            ec = 1'b1;
                            m_st = 5;
                            if (matchresult == 2'b11) ee = 1'b1;
                            else if (!m_fin()) begin
                                m_round++;
                                if (matchresult == 2'b01) m_win++;
                                if (matchresult == 2'b10) m_lose++;
                                es = 1'b1;
                            end
                        end else begin
                            m_st = 1;
                        end
                    end else begin
                        ee = 1'b1;
                    end
                end
                5: if (b == 1) begin
                    m_st = m_fin() ? 6 : 1;
                    m_sub1 = 1'b0; m_sub2 = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (err === 1'b1)               n_err++;
        if (cmp_start === 1'b1)         n_cmp++;
        if (scoreupdate_pulse === 1'b1) n_score++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", state, m_st);
            check("p1_handcard", p1_handcard, m_h1);
            check("p2_handcard", p2_handcard, m_h2);
            check("round", round, m_round);
            check("win", win, m_win);
            check("lose", lose, m_lose);
            check("fin", fin, m_fin());
            check("idle_pulses", {cmp_start, scoreupdate_pulse, err}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit [4:0] m);
        {btn_restart, btn_confirm, btn_p1, btn_p2, btn_start} = m;
    endtask

    task automatic press(input bit [4:0] m);
        int e0, c0, s0;
        bit ee, ec, es;
        e0 = n_err; c0 = n_cmp; s0 = n_score;
        chk_en = 1'b0;
        drive(m); tick(); tick();
        drive(5'b0); tick(); tick();
        model_apply(m, ee, ec, es);
        check("err_pulses", n_err - e0, ee);
        check("cmp_pulses", n_cmp - c0, ec);
        check("score_pulses", n_score - s0, es);
        chk_en = 1'b1;
        tick();
    endtask

    task automatic submit(input int p, input int idx);
        tile_sw = NT'(1) << idx;
        press(p == 1 ? M_P1 : M_P2);
        press(M_CONF);
    endtask

    initial begin
        int c0, s0, k;
        bit [4:0] m;
        model_clear();
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_counts", {round, win, lose}, 0);
        check("rst_hands", {p1_handcard, p2_handcard}, 0);
        check("rst_flags", {fin, cmp_start, scoreupdate_pulse, err}, 0);
        resetn = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();

        // First round: P1 plays 5, P2 plays 3, P1 wins
        press(M_START);
        submit(1, 5);
        matchresult = 2'b01;
        c0 = n_cmp; s0 = n_score;
        submit(2, 3);
        check("r1_cmp_start", n_cmp - c0, 1);
        check("r1_score_pulse", n_score - s0, 1);
        check("r1_counts", {win, lose, round}, {4'd1, 4'd0, 4'd1});
        check("r1_hands", {p1_handcard, p2_handcard}, {4'd5, 4'd3});
        check("r1_state", state, 5);

        // Reused and malformed tiles
        press(M_CONF);
        press(M_P1);
        tile_sw = NT'(1) << 5;
        press(M_CONF);
        check("replay_state", state, 2);
        check("replay_hand", p1_handcard, 5);
        tile_sw = '0;
        press(M_CONF);
        tile_sw = 9'b000000011;
        press(M_CONF);
        check("bad_sel_state", state, 2);
        tile_sw = 9'b000000001;
        press(M_CONF);
        check("tile0_hand", p1_handcard, 0);
        check("tile0_state", state, 1);

        // Five P2 wins end the game early
        press(M_RST);
        press(M_START);
        matchresult = 2'b10;
        for (int r = 0; r < 5; r++) begin
            submit(1, r);
            submit(2, r);
            if (r < 4) press(M_CONF);
        end
        check("lose5", lose, 5);
        check("lose5_fin", fin, 1);
        press(M_CONF);
        check("over_state", state, 6);
        press(M_P1);
        press(M_CONF);
        check("over_hold", state, 6);
        press(M_RST);
        check("restart_state", state, 0);
        check("restart_counts", {round, win, lose}, 0);

        // Nine mixed rounds end on the round limit
        press(M_START);
        for (int r = 0; r < 9; r++) begin
            matchresult = (r % 3 == 0) ? 2'b01 : (r % 3 == 1) ? 2'b10 : 2'b00;
            submit(1, r);
            submit(2, 8 - r);
            if (r < 8) press(M_CONF);
        end
        check("nine_round", round, 9);
        check("nine_fin", fin, 1);
        check("nine_score", {win, lose}, {4'd3, 4'd3});
        press(M_CONF);

        // Restart beats a simultaneous confirm in P2_TURN
        press(M_RST);
        press(M_START);
        matchresult = 2'b01;
        submit(1, 2);
        press(M_P2);
        tile_sw = NT'(1) << 4;
        c0 = n_score;
        press(M_RST | M_CONF);
        check("rst_conf_state", state, 0);
        check("rst_conf_score", n_score - c0, 0);
        check("rst_conf_counts", {round, win, lose, p1_handcard}, 0);

        // Async reset in the middle of COMPARE
        press(M_START);
        submit(1, 1);
        press(M_P2);
        tile_sw = NT'(1) << 6;
        chk_en = 1'b0;
        btn_confirm = 1'b1;
        for (int i = 0; i < 8 && state != 3'd4; i++) tick();
        check("reach_compare", state, 4);
        resetn = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_counts", {round, win, lose}, 0);
        check("mid_rst_hands", {p1_handcard, p2_handcard}, 0);
        check("mid_rst_flags", {fin, cmp_start, scoreupdate_pulse, err}, 0);
        btn_confirm = 1'b0;
        model_clear();
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();

        // Random presses
        for (int it = 0; it < 600; it++) begin
            k = $urandom_range(0, 99);
            if (k < 70)      tile_sw = NT'(1) << $urandom_range(0, NT - 1);
            else if (k < 82) tile_sw = '0;
            else             tile_sw = NT'($urandom);
            matchresult = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 99);
            if (k < 2 || (m_st == 6 && k < 60)) m = M_RST;
            else if (k < 12)                    m = 5'($urandom);
            else if (k < 20)                    m = 5'b00001 << $urandom_range(0, 3);
            else begin
                case (m_st)
                    0:       m = M_START;
                    1:       m = $urandom_range(0, 1) ? M_P1 : M_P2;
                    default: m = M_CONF;
                endcase
            end
            press(m);
        end

        chk_en = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
